ysyx_22040386_lsu: RTL and testbench



---
 rtl/ysyx_22040386_lsu_if.sv | 37 +++
 rtl/ysyx_22040386_lsu.sv | 94 +++++++++
 tb/tb_ysyx_22040386_lsu.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040386_lsu_if.sv
// ysyx_22040386_lsu_if: execute-side op, memory request/response and write-back bundle of the LSU
interface ysyx_22040386_lsu_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic              in_mem_rd;
    logic              in_mem_wr;
    logic [2:0]        in_funct3;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_wdata;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [7:0]        req_wmask;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_misalign;
    modport master (
        input  in_valid, in_mem_rd, in_mem_wr, in_funct3, in_addr, in_wdata,
               req_ready, resp_valid, resp_rdata, out_ready,
        output in_ready, req_valid, req_we, req_addr, req_wdata, req_wmask,
               out_valid, out_data, out_misalign
    );
    modport slave (
        output in_valid, in_mem_rd, in_mem_wr, in_funct3, in_addr, in_wdata,
               req_ready, resp_valid, resp_rdata, out_ready,
        input  in_ready, req_valid, req_we, req_addr, req_wdata, req_wmask,
               out_valid, out_data, out_misalign
    );
endinterface

// File: rtl/ysyx_22040386_lsu.sv
// ysyx_22040386_lsu: single-outstanding load/store unit with byte masking and load extension
module ysyx_22040386_lsu #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    ysyx_22040386_lsu_if.master         bus
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
    state_t            state_q;
    logic              req_valid_q, req_we_q, out_valid_q, out_mis_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [DATA_W-1:0] req_wdata_q, out_data_q, rdata_sh, load_d;
    logic [7:0]        req_wmask_q, mask_d;
    logic [2:0]        f3_q, off_q, off;
    logic [1:0]        size;
    logic              bad_d;
    always_comb begin
        off      = bus.in_addr[2:0];
        size     = bus.in_funct3[1:0];
        bad_d    = (bus.in_funct3 == 3'b111) | (bus.in_mem_wr & bus.in_funct3[2]) |
                   (size == 2'd1 ? off[0] : size == 2'd2 ? |off[1:0] : size == 2'd3 ? |off : 1'b0);
        mask_d   = (size == 2'd0 ? 8'h01 : size == 2'd1 ? 8'h03 : size == 2'd2 ? 8'h0F : 8'hFF) << off;
        rdata_sh = bus.resp_rdata >> {off_q, 3'b000};
        // funct3[2] selects zero extension
        load_d   = f3_q[1:0] == 2'd0 ? {{56{~f3_q[2] & rdata_sh[7]}}, rdata_sh[7:0]} :
                   f3_q[1:0] == 2'd1 ? {{48{~f3_q[2] & rdata_sh[15]}}, rdata_sh[15:0]} :
                   f3_q[1:0] == 2'd2 ? {{32{~f3_q[2] & rdata_sh[31]}}, rdata_sh[31:0]} : rdata_sh;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_valid_q <= 1'b0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wmask_q <= '0;
            out_valid_q <= 1'b0;
            out_mis_q   <= 1'b0;
            out_data_q  <= '0;
            f3_q        <= '0;
            off_q       <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    f3_q        <= bus.in_funct3;
                    off_q       <= off;
                    req_we_q    <= bus.in_mem_wr;
                    req_addr_q  <= {bus.in_addr[ADDR_W-1:3], 3'b000};
                    req_wdata_q <= bus.in_wdata << {off, 3'b000};
                    req_wmask_q <= bus.in_mem_wr ? mask_d : 8'h00;
                    if (!(bus.in_mem_rd | bus.in_mem_wr)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        out_data_q  <= bus.in_addr;
                        out_mis_q   <= 1'b0;
                    end else if (bad_d) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        out_data_q  <= '0;
                        out_mis_q   <= 1'b1;
                    end else begin
                        state_q     <= REQ;
                        req_valid_q <= 1'b1;
                    end
                end
                REQ: if (bus.req_ready) begin
                    state_q     <= RESP;
                    req_valid_q <= 1'b0;
                end
                RESP: if (bus.resp_valid) begin
                    state_q     <= DONE;
                    out_valid_q <= 1'b1;
                    out_data_q  <= req_we_q ? '0 : load_d;
                    out_mis_q   <= 1'b0;
                end
                DONE: if (bus.out_ready) begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end
    assign bus.in_ready     = state_q == IDLE;
    assign bus.req_valid    = req_valid_q;
    assign bus.req_we       = req_we_q;
    assign bus.req_addr     = req_addr_q;
    assign bus.req_wdata    = req_wdata_q;
    assign bus.req_wmask    = req_wmask_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_misalign = out_mis_q;
endmodule

// File: tb/tb_ysyx_22040386_lsu.sv
// tb_ysyx_22040386_lsu: directed scenarios for the load/store unit
module tb_ysyx_22040386_lsu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    ysyx_22040386_lsu_if bus ();
    ysyx_22040386_lsu dut (.clk(clk), .rst(rst), .bus(bus.master));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] wdata);
        bus.in_mem_rd = rd;
        bus.in_mem_wr = wr;
        bus.in_funct3 = f3;
        bus.in_addr   = addr;
        bus.in_wdata  = wdata;
        bus.in_valid  = 1'b1;
        step();
        bus.in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (bus.req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b exp 0", bus.req_valid); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        checks++; if (bus.out_misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b exp 0", bus.out_misalign); end
        checks++; if (bus.out_data !== 64'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0", bus.out_data); end
        checks++; if (bus.req_addr !== 64'h0 || bus.req_wdata !== 64'h0) begin errors++; $display("FAIL reset_req_fields got %h/%h exp 0/0", bus.req_addr, bus.req_wdata); end
        checks++; if (bus.req_wmask !== 8'h0 || bus.req_we !== 1'b0) begin errors++; $display("FAIL reset_mask_we got %h/%b exp 00/0", bus.req_wmask, bus.req_we); end
        rst = 1'b0;
        step();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    endtask

    task automatic test_nonmem();
        bus.out_ready = 1'b1;
        accept(1'b0, 1'b0, 3'b000, 64'h1234, 64'h0);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL nonmem_valid got %b exp 1", bus.out_valid); end
        checks++; if (bus.out_data !== 64'h1234) begin errors++; $display("FAIL nonmem_data got %h exp %h", bus.out_data, 64'h1234); end
        checks++; if (bus.req_valid !== 1'b0 || bus.out_misalign !== 1'b0) begin errors++; $display("FAIL nonmem_req_mis got %b/%b exp 0/0", bus.req_valid, bus.out_misalign); end
        step();
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL nonmem_return got %b/%b exp 0/1", bus.out_valid, bus.in_ready); end
    endtask

    task automatic test_load(input string name, input logic [2:0] f3, input logic [63:0] addr,
                             input logic [63:0] rdata, input logic [63:0] exp);
        bus.out_ready = 1'b1;
        accept(1'b1, 1'b0, f3, addr, 64'h0);
        checks++; if (bus.req_valid !== 1'b1 || bus.req_we !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL %s_req got v%b we%b rdy%b exp v1 we0 rdy0", name, bus.req_valid, bus.req_we, bus.in_ready); end
        checks++; if (bus.req_addr !== {addr[63:3], 3'b000}) begin errors++; $display("FAIL %s_addr got %h exp %h", name, bus.req_addr, {addr[63:3], 3'b000}); end
        bus.req_ready = 1'b1;
        step();
        bus.req_ready = 1'b0;
        checks++; if (bus.req_valid !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL %s_resp_wait got %b/%b exp 0/0", name, bus.req_valid, bus.out_valid); end
        bus.resp_valid = 1'b1;
        bus.resp_rdata = rdata;
        step();
        bus.resp_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_misalign !== 1'b0) begin errors++; $display("FAIL %s_done got %b/%b exp 1/0", name, bus.out_valid, bus.out_misalign); end
        checks++; if (bus.out_data !== exp) begin errors++; $display("FAIL %s_data got %h exp %h", name, bus.out_data, exp); end
        step();
    endtask

    task automatic test_store(input string name, input logic rd, input logic [2:0] f3, input logic [63:0] addr,
                              input logic [63:0] wdata, input logic [7:0] exp_mask, input logic [63:0] exp_wdata);
        bus.out_ready = 1'b1;
        accept(rd, 1'b1, f3, addr, wdata);
        checks++; if (bus.req_valid !== 1'b1 || bus.req_we !== 1'b1) begin errors++; $display("FAIL %s_req got v%b we%b exp v1 we1", name, bus.req_valid, bus.req_we); end
        checks++; if (bus.req_wmask !== exp_mask) begin errors++; $display("FAIL %s_mask got %h exp %h", name, bus.req_wmask, exp_mask); end
        checks++; if (bus.req_wdata !== exp_wdata) begin errors++; $display("FAIL %s_wdata got %h exp %h", name, bus.req_wdata, exp_wdata); end
        bus.req_ready = 1'b1;
        step();
        bus.req_ready = 1'b0;
        bus.resp_valid = 1'b1;
        bus.resp_rdata = 64'hDEADBEEF_CAFEF00D;
        step();
        bus.resp_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 64'h0 || bus.out_misalign !== 1'b0) begin errors++; $display("FAIL %s_done got v%b d%h m%b exp v1 d0 m0", name, bus.out_valid, bus.out_data, bus.out_misalign); end
        step();
    endtask

    task automatic test_misalign(input string name, input logic rd, input logic wr,
                                 input logic [2:0] f3, input logic [63:0] addr);
        bus.out_ready = 1'b1;
        accept(rd, wr, f3, addr, 64'hFFFF_FFFF_FFFF_FFFF);
        checks++; if (bus.req_valid !== 1'b0 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL %s_flow got req%b out%b exp req0 out1", name, bus.req_valid, bus.out_valid); end
        checks++; if (bus.out_misalign !== 1'b1 || bus.out_data !== 64'h0) begin errors++; $display("FAIL %s_result got m%b d%h exp m1 d0", name, bus.out_misalign, bus.out_data); end
        step();
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b1;
        accept(1'b1, 1'b0, 3'b011, 64'h8000_0010, 64'h0);
        bus.in_mem_rd = 1'b0;
        bus.in_mem_wr = 1'b0;
        bus.in_addr   = 64'h55;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.req_valid !== 1'b1 || bus.req_addr !== 64'h8000_0010 || bus.req_we !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_req_hold%0d got v%b a%h we%b rdy%b exp v1 a80000010 we0 rdy0", i, bus.req_valid, bus.req_addr, bus.req_we, bus.in_ready); end
            step();
        end
        bus.req_ready = 1'b1;
        step();
        bus.req_ready = 1'b0;
        checks++; if (bus.req_valid !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_resp got v%b rdy%b exp v0 rdy0", bus.req_valid, bus.in_ready); end
        bus.resp_valid = 1'b1;
        bus.resp_rdata = 64'h1122_3344_5566_7788;
        bus.out_ready  = 1'b0;
        step();
        bus.resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 64'h1122_3344_5566_7788 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_out_hold%0d got v%b d%h rdy%b exp v1 d1122334455667788 rdy0", i, bus.out_valid, bus.out_data, bus.in_ready); end
            step();
        end
        bus.out_ready = 1'b1;
        step();
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_no_same_cycle got v%b rdy%b exp v0 rdy1", bus.out_valid, bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 64'h55) begin errors++; $display("FAIL bp_second_op got v%b d%h exp v1 d55", bus.out_valid, bus.out_data); end
        step();
    endtask

    task automatic test_reset_inflight();
        bus.out_ready = 1'b1;
        accept(1'b1, 1'b0, 3'b000, 64'h8000_0003, 64'h0);
        checks++; if (bus.req_valid !== 1'b1) begin errors++; $display("FAIL rst_req_pre got %b exp 1", bus.req_valid); end
        rst = 1'b1;
        #1;
        checks++; if (bus.req_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_req_async got v%b rdy%b exp v0 rdy1", bus.req_valid, bus.in_ready); end
        rst = 1'b0;
        step();
        accept(1'b1, 1'b0, 3'b000, 64'h8000_0003, 64'h0);
        bus.req_ready = 1'b1;
        step();
        bus.req_ready = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (bus.req_valid !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_resp_async got req%b out%b rdy%b exp 0/0/1", bus.req_valid, bus.out_valid, bus.in_ready); end
        rst = 1'b0;
        bus.resp_valid = 1'b1;
        bus.resp_rdata = 64'h0000_0000_80FF_0000;
        step();
        bus.resp_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.req_valid !== 1'b0 || bus.out_data !== 64'h0) begin errors++; $display("FAIL rst_stray_resp got out%b req%b d%h exp 0/0/0", bus.out_valid, bus.req_valid, bus.out_data); end
        step();
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_stray_later got out%b rdy%b exp 0/1", bus.out_valid, bus.in_ready); end
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_mem_rd  = 1'b0;
        bus.in_mem_wr  = 1'b0;
        bus.in_funct3  = 3'b000;
        bus.in_addr    = 64'h0;
        bus.in_wdata   = 64'h0;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = 64'h0;
        bus.out_ready  = 1'b0;
        test_reset();
        test_nonmem();
        test_load("lb",  3'b000, 64'h8000_0003, 64'h0000_0000_80FF_0000, 64'hFFFF_FFFF_FFFF_FF80);
        test_load("lbu", 3'b100, 64'h8000_0003, 64'h0000_0000_80FF_0000, 64'h0000_0000_0000_0080);
        test_load("lh",  3'b001, 64'h8000_0006, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001);
        test_load("lhu", 3'b101, 64'h8000_0002, 64'h0000_0000_F00D_0000, 64'h0000_0000_0000_F00D);
        test_load("lw",  3'b010, 64'h8000_0004, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321);
        test_load("lwu", 3'b110, 64'h8000_0004, 64'hF000_0000_1234_5678, 64'h0000_0000_F000_0000);
        test_load("ld",  3'b011, 64'h8000_0008, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
        test_store("sh", 1'b0, 3'b001, 64'h8000_0006, 64'h0000_0000_0000_BEEF, 8'hC0, 64'hBEEF_0000_0000_0000);
        test_store("sb_rdwr", 1'b1, 3'b000, 64'h8000_0005, 64'h0000_0000_0000_00AB, 8'h20, 64'h0000_AB00_0000_0000);
        test_store("sw", 1'b0, 3'b010, 64'h8000_0004, 64'h0000_0000_CAFE_BABE, 8'hF0, 64'hCAFE_BABE_0000_0000);
        test_store("sd", 1'b0, 3'b011, 64'h8000_0000, 64'h0011_2233_4455_6677, 8'hFF, 64'h0011_2233_4455_6677);
        test_misalign("lw_mis",  1'b1, 1'b0, 3'b010, 64'h8000_0002);
        test_misalign("lh_mis",  1'b1, 1'b0, 3'b001, 64'h8000_0001);
        test_misalign("ld_mis",  1'b1, 1'b0, 3'b011, 64'h8000_0004);
        test_misalign("f3_111",  1'b1, 1'b0, 3'b111, 64'h8000_0000);
        test_misalign("st_unsg", 1'b0, 1'b1, 3'b100, 64'h8000_0000);
        test_misalign("sw_mis",  1'b0, 1'b1, 3'b010, 64'h8000_0006);
        test_backpressure();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
